// File: rtl/xmr_probe_pkg.sv
// Shared types and helpers for the xmr_probe_bank channel bank and its probe port.
package xmr_probe_pkg;

   typedef enum logic {MODE_TOGGLE, MODE_COUNT} ch_mode_e;

   // One extra MSB beyond what NUM_CH needs, so out-of-range indices can be requested.
   function automatic int ch_idx_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/xmr_probe_channel.sv
// One channel: prescale counter, WIDTH-bit state register (toggle or count) and update tick.
module xmr_probe_channel
   import xmr_probe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  ch_mode_e         mode_i,
   input  logic [DIV_W-1:0] div_i,
   output logic [WIDTH-1:0] state_o,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic             tick_q, tick_d;

   // ">=" so that lowering div below the running count fires on the very next cycle.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      tick_d  = 1'b0;
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q >= div_i) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         if (mode_i == MODE_COUNT) state_d = state_q + WIDTH'(1);
         else                      state_d = ~state_q;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         tick_q  <= tick_d;
      end
   end

   assign state_o = state_q;
   assign tick_o  = tick_q;

endmodule

// File: rtl/xmr_probe_bank.sv
// NUM_CH prescaled toggle/count channels with a one-outstanding snapshot probe port.
// Optional feature macro: XMR_PROBE_PARITY_EN adds probe_rsp_parity.
module xmr_probe_bank
   import xmr_probe_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int DIV_W  = 8
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic [NUM_CH-1:0]           ch_mode,
   input  logic [DIV_W-1:0]            div,
   output logic [NUM_CH*WIDTH-1:0]     ch_state,
   output logic [NUM_CH-1:0]           ch_tick,
   input  logic                        probe_req_valid,
   input  logic [ch_idx_w(NUM_CH)-1:0] probe_req_ch,
   output logic                        probe_req_ready,
   output logic                        probe_rsp_valid,
   input  logic                        probe_rsp_ready,
   output logic [WIDTH-1:0]            probe_rsp_data,
   output logic                        probe_rsp_err
`ifdef XMR_PROBE_PARITY_EN
   ,output logic                       probe_rsp_parity
`endif
);

   localparam int IDX_W = ch_idx_w(NUM_CH);

   logic [WIDTH-1:0] state_w [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      xmr_probe_channel #(
         .WIDTH (WIDTH),
         .DIV_W (DIV_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en_i    (ch_en[i]),
         .mode_i  (ch_mode_e'(ch_mode[i])),
         .div_i   (div),
         .state_o (state_w[i]),
         .tick_o  (ch_tick[i])
      );
      assign ch_state[i*WIDTH +: WIDTH] = state_w[i];
   end

   logic [WIDTH-1:0] sel_data;
   logic             sel_err;

   always_comb begin
      sel_data = '0;
      sel_err  = (probe_req_ch >= IDX_W'(NUM_CH));
      for (int i = 0; i < NUM_CH; i++) begin
         if (probe_req_ch == IDX_W'(i)) sel_data = state_w[i];
      end
   end

   // Handshake: a request is taken when valid && ready; ready is high whenever the
   // response slot is empty or is being drained this cycle, so a drain and a new
   // accept in the same cycle refill the slot with no bubble. The response holds
   // valid/data/err stable until rsp_ready.
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic             req_accept;

   assign probe_req_ready = !rsp_valid_q || probe_rsp_ready;
   assign req_accept      = probe_req_valid && probe_req_ready;

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      if (req_accept) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = sel_data;
         rsp_err_d   = sel_err;
      end else if (probe_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign probe_rsp_valid = rsp_valid_q;
   assign probe_rsp_data  = rsp_data_q;
   assign probe_rsp_err   = rsp_err_q;

`ifdef XMR_PROBE_PARITY_EN
   // sel_data is zero for an out-of-range index, so err responses carry parity 0.
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (req_accept) parity_d = ^sel_data;
   end

   always_ff @(posedge clk) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= parity_d;
   end

   assign probe_rsp_parity = parity_q;
`endif

endmodule

// File: tb/tb_xmr_probe_bank.sv
// Bench for xmr_probe_bank: directed scenarios plus random traffic against an integer model.
module tb_xmr_probe_bank;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int DIV_W  = 8;
   localparam int IDX_W  = $clog2(NUM_CH) + 1;
   localparam int MOD    = 1 << WIDTH;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH-1:0]       ch_mode;
   logic [DIV_W-1:0]        div;
   logic [NUM_CH*WIDTH-1:0] ch_state;
   logic [NUM_CH-1:0]       ch_tick;
   logic                    probe_req_valid;
   logic [IDX_W-1:0]        probe_req_ch;
   logic                    probe_req_ready;
   logic                    probe_rsp_valid;
   logic                    probe_rsp_ready;
   logic [WIDTH-1:0]        probe_rsp_data;
   logic                    probe_rsp_err;
`ifdef XMR_PROBE_PARITY_EN
   logic                    probe_rsp_parity;
`endif

   always #5 clk = ~clk;

   xmr_probe_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .ch_en           (ch_en),
      .ch_mode         (ch_mode),
      .div             (div),
      .ch_state        (ch_state),
      .ch_tick         (ch_tick),
      .probe_req_valid (probe_req_valid),
      .probe_req_ch    (probe_req_ch),
      .probe_req_ready (probe_req_ready),
      .probe_rsp_valid (probe_rsp_valid),
      .probe_rsp_ready (probe_rsp_ready),
      .probe_rsp_data  (probe_rsp_data),
      .probe_rsp_err   (probe_rsp_err)
`ifdef XMR_PROBE_PARITY_EN
      ,.probe_rsp_parity (probe_rsp_parity)
`endif
   );

   // Reference model: plain integers per channel, expected snapshot queue {err, data}.
   int             m_state [NUM_CH];
   int             m_cnt   [NUM_CH];
   int             m_tick  [NUM_CH];
   logic [WIDTH:0] exp_q[$];
   int             n_pass = 0;
   int             n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         m_state[i] = 0;
         m_cnt[i]   = 0;
         m_tick[i]  = 0;
      end
      exp_q.delete();
   endtask

   // One clock: check ready, advance model with current inputs, clock, compare outputs.
   task automatic cycle();
      bit ready;
      bit accept;
      #1;
      ready = (exp_q.size() == 0) || (probe_rsp_ready === 1'b1);
      check("req_ready", 32'(probe_req_ready), 32'(ready));
      if (rst) begin
         model_clear();
      end else begin
         accept = (probe_req_valid === 1'b1) && ready;
         if (exp_q.size() != 0 && probe_rsp_ready) void'(exp_q.pop_front());
         if (accept) begin
            if (int'(probe_req_ch) < NUM_CH) exp_q.push_back({1'b0, WIDTH'(m_state[probe_req_ch])});
            else                             exp_q.push_back({1'b1, {WIDTH{1'b0}}});
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
               m_cnt[i]  = 0;
               m_tick[i] = 0;
            end else if (m_cnt[i] >= int'(div)) begin
               m_cnt[i]   = 0;
               m_tick[i]  = 1;
               m_state[i] = ch_mode[i] ? (m_state[i] + 1) % MOD : (MOD - 1) - m_state[i];
            end else begin
               m_cnt[i]++;
               m_tick[i] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("ch%0d_state", i), 32'(ch_state[i*WIDTH +: WIDTH]), 32'(m_state[i]));
         check($sformatf("ch%0d_tick", i), 32'(ch_tick[i]), 32'(m_tick[i]));
      end
      check("rsp_valid", 32'(probe_rsp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("rsp_data", 32'(probe_rsp_data), 32'(exp_q[0][WIDTH-1:0]));
         check("rsp_err", 32'(probe_rsp_err), 32'(exp_q[0][WIDTH]));
`ifdef XMR_PROBE_PARITY_EN
         check("rsp_parity", 32'(probe_rsp_parity),
               32'(exp_q[0][WIDTH] ? 1'b0 : ^exp_q[0][WIDTH-1:0]));
`endif
      end
   endtask

   task automatic start(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] mode,
                        input logic [DIV_W-1:0] d);
      rst = 1'b1;
      ch_en = en;
      ch_mode = mode;
      div = d;
      probe_req_valid = 1'b0;
      probe_req_ch = '0;
      probe_rsp_ready = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   logic [WIDTH-1:0] prev;

   initial begin
      rst = 1'b1;
      ch_en = '0;
      ch_mode = '0;
      div = '0;
      probe_req_valid = 1'b0;
      probe_req_ch = '0;
      probe_rsp_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(ch_state), 32'h0);
      check("rst_rsp_valid", 32'(probe_rsp_valid), 32'h0);

      // Toggle at div=0: 00 -> FF -> 00 with tick held high.
      start(4'b0001, 4'b0000, 8'd0);
      check("tog_first", 32'(ch_state[7:0]), 32'h00);
      cycle();
      check("tog_ff", 32'(ch_state[7:0]), 32'hFF);
      check("tog_tick1", 32'(ch_tick[0]), 32'h1);
      cycle();
      check("tog_00", 32'(ch_state[7:0]), 32'h00);
      check("tog_tick2", 32'(ch_tick[0]), 32'h1);

      // Count at div=2: first tick on the third cycle, then wrap FF -> 00.
      start(4'b0001, 4'b0001, 8'd2);
      repeat (3) cycle();
      check("cnt_first", 32'(ch_state[7:0]), 32'h01);
      for (int k = 0; k < 780; k++) begin
         prev = ch_state[7:0];
         cycle();
         if (prev == 8'hFF && ch_tick[0]) check("cnt_wrap", 32'(ch_state[7:0]), 32'h00);
      end

      // Count at 5 with div=7, then div lowered to 3: tick on the next cycle.
      start(4'b0001, 4'b0001, 8'd7);
      repeat (5) cycle();
      div = 8'd3;
      cycle();
      check("div_lower_tick", 32'(ch_tick[0]), 32'h1);
      cycle();
      check("div_lower_after", 32'(ch_tick[0]), 32'h0);

      // Bring ch2 to 0x5A, freeze it, probe with a stalled consumer.
      start(4'b0100, 4'b0100, 8'd0);
      repeat (8'h5A) cycle();
      ch_en = '0;
      probe_req_valid = 1'b1;
      probe_req_ch = 3'd2;
      probe_rsp_ready = 1'b0;
      cycle();
      for (int k = 0; k < 4; k++) begin
         check("stall_data", 32'(probe_rsp_data), 32'h5A);
         check("stall_ready", 32'(probe_req_ready), 32'h0);
         cycle();
      end
      probe_rsp_ready = 1'b1;
      #1;
      check("drain_ready", 32'(probe_req_ready), 32'h1);
      cycle();
      check("b2b_valid", 32'(probe_rsp_valid), 32'h1);
      probe_req_ch = 3'(NUM_CH);
      cycle();
      check("oor_err", 32'(probe_rsp_err), 32'h1);
      check("oor_data", 32'(probe_rsp_data), 32'h0);
      probe_req_valid = 1'b0;
      cycle();

      // ch1 to 0x07 for an odd-parity snapshot.
      start(4'b0010, 4'b0010, 8'd0);
      repeat (7) cycle();
      ch_en = '0;
      probe_req_valid = 1'b1;
      probe_req_ch = 3'd1;
      probe_rsp_ready = 1'b0;
      cycle();
      check("p7_data", 32'(probe_rsp_data), 32'h07);
`ifdef XMR_PROBE_PARITY_EN
      check("p7_parity", 32'(probe_rsp_parity), 32'h1);
`endif
      // Reset with a pending response drops it.
      probe_req_valid = 1'b0;
      rst = 1'b1;
      cycle();
      check("rst_drop_valid", 32'(probe_rsp_valid), 32'h0);
      check("rst_drop_state", 32'(ch_state), 32'h0);
      rst = 1'b0;

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom);
         if ($urandom_range(0, 15) == 0) ch_mode = NUM_CH'($urandom);
         if ($urandom_range(0, 31) == 0) div = DIV_W'($urandom_range(0, 6));
         probe_req_valid = $urandom_range(0, 1) == 1;
         probe_req_ch = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
         probe_rsp_ready = $urandom_range(0, 2) != 0;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
